// File: rtl/uart_pkg.sv
// Shared types and constants for the boot-time UART program loader.
package uart_pkg;

  localparam int         WORD_BYTES    = 4;
  localparam logic [7:0] ACK_BYTE_DFLT = 8'hAA;
  localparam logic [7:0] NAK_BYTE_DFLT = 8'h55;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RX_REQ,
    S_RX_WAIT,
    S_LEN_CHK,
    S_WRITE,
    S_TX_ACK,
    S_TX_WAIT_A,
    S_TX_SUM,
    S_TX_WAIT_S,
    S_TX_NAK,
    S_TX_WAIT_N,
    S_DONE,
    S_ERR
  } loader_state_t;

endpackage

// File: rtl/ldr_word_asm.sv
// Little-endian byte-to-word assembler with a payload checksum accumulator.
// word is only meaningful in the cycle word_valid is high (it merges the 4th byte combinationally).
module ldr_word_asm
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        valid,
  input  logic        sum_en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [7:0]  sum
);

  logic [23:0] acc;
  logic [1:0]  byte_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc      <= '0;
      byte_cnt <= '0;
      sum      <= '0;
    end else if (clear) begin
      acc      <= '0;
      byte_cnt <= '0;
      sum      <= '0;
    end else if (valid) begin
      case (byte_cnt)
        2'd0:    acc[7:0]   <= din;
        2'd1:    acc[15:8]  <= din;
        2'd2:    acc[23:16] <= din;
        default: ;
      endcase
      byte_cnt <= byte_cnt + 2'd1;
      if (sum_en) sum <= sum + din;
    end
  end

  assign word_valid = valid && (byte_cnt == 2'(WORD_BYTES - 1));
  assign word       = {din, acc};

endmodule

// File: rtl/uart_loader.sv
// Boot loader: receives a 32-bit word count then that many words over UART into imem from address 0,
// then replies ACK + checksum, or NAK when the count exceeds imem capacity.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | waiting for start after reset
// S_RX_REQ    | issue a receive request to uart_unit
// S_RX_WAIT   | wait for a received byte, feed it to the assembler
// S_LEN_CHK   | judge the received word count against capacity
// S_WRITE     | imem write strobe active, advance word index
// S_TX_ACK    | issue ACK byte send
// S_TX_WAIT_A | wait for ACK send to complete
// S_TX_SUM    | issue checksum byte send
// S_TX_WAIT_S | wait for checksum send to complete
// S_TX_NAK    | issue NAK byte send
// S_TX_WAIT_N | wait for NAK send to complete
// S_DONE      | load succeeded (load_done sticky), start reloads
// S_ERR       | length rejected (err sticky), start reloads
module uart_loader
  import uart_pkg::*;
#(
  parameter int         ADDR_W   = 14,
  parameter logic [7:0] ACK_BYTE = ACK_BYTE_DFLT,
  parameter logic [7:0] NAK_BYTE = NAK_BYTE_DFLT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              uart_go,
  output logic              rors,
  output logic [7:0]        txdata,
  input  logic              uart_done,
  input  logic [7:0]        rxdata,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              err
);

  // 33 bits so a full 2**ADDR_W capacity never truncates against the 32-bit length
  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

  loader_state_t     state;
  logic              len_phase;
  logic [31:0]       len;
  logic [ADDR_W-1:0] word_idx;

  logic        asm_clear;
  logic        asm_valid;
  logic        word_valid;
  logic [31:0] word;
  logic [7:0]  sum;

  assign asm_clear = start && (state inside {S_IDLE, S_DONE, S_ERR});
  assign asm_valid = uart_done && (state == S_RX_WAIT);

  ldr_word_asm u_asm (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (asm_clear),
    .valid      (asm_valid),
    .sum_en     (!len_phase),
    .din        (rxdata),
    .word       (word),
    .word_valid (word_valid),
    .sum        (sum)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      len_phase  <= 1'b0;
      len        <= '0;
      word_idx   <= '0;
      uart_go    <= 1'b0;
      rors       <= 1'b0;
      txdata     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      err        <= 1'b0;
    end else begin
      uart_go <= 1'b0;
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state     <= S_RX_REQ;
            len_phase <= 1'b1;
            len       <= '0;
            word_idx  <= '0;
            busy      <= 1'b1;
            load_done <= 1'b0;
            err       <= 1'b0;
          end
        end
        S_RX_REQ: begin
          uart_go <= 1'b1;
          rors    <= 1'b0;
          state   <= S_RX_WAIT;
        end
        S_RX_WAIT: begin
          if (uart_done) begin
            if (word_valid && len_phase) begin
              len   <= word;
              state <= S_LEN_CHK;
            end else if (word_valid) begin
              // strobe lands the cycle after the 4th byte
              imem_we    <= 1'b1;
              imem_addr  <= word_idx;
              imem_wdata <= word;
              state      <= S_WRITE;
            end else begin
              state <= S_RX_REQ;
            end
          end
        end
        S_LEN_CHK: begin
          len_phase <= 1'b0;
          if ({1'b0, len} > CAPACITY) state <= S_TX_NAK;
          else if (len == '0)         state <= S_TX_ACK;
          else                        state <= S_RX_REQ;
        end
        S_WRITE: begin
          word_idx <= word_idx + ADDR_W'(1);
          if (32'(word_idx) == len - 32'd1) state <= S_TX_ACK;
          else                              state <= S_RX_REQ;
        end
        S_TX_ACK: begin
          uart_go <= 1'b1;
          rors    <= 1'b1;
          txdata  <= ACK_BYTE;
          state   <= S_TX_WAIT_A;
        end
        S_TX_WAIT_A: if (uart_done) state <= S_TX_SUM;
        S_TX_SUM: begin
          uart_go <= 1'b1;
          rors    <= 1'b1;
          txdata  <= sum;
          state   <= S_TX_WAIT_S;
        end
        S_TX_WAIT_S: begin
          if (uart_done) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            load_done <= 1'b1;
          end
        end
        S_TX_NAK: begin
          uart_go <= 1'b1;
          rors    <= 1'b1;
          txdata  <= NAK_BYTE;
          state   <= S_TX_WAIT_N;
        end
        S_TX_WAIT_N: begin
          if (uart_done) begin
            state <= S_ERR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader (ADDR_W=4) with a randomized-latency uart_unit model.
module tb_uart_loader;

  localparam int ADDR_W = 4;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic              uart_go;
  logic              rors;
  logic [7:0]        txdata;
  logic              uart_done;
  logic [7:0]        rxdata;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              load_done;
  logic              err;

  logic model_done;
  logic spur_done;
  bit   spur_en;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;

  logic [7:0]        rx_q[$];
  logic [7:0]        tx_log[$];
  logic [7:0]        pay_q[$];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  assign uart_done = model_done | spur_done;

  uart_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .uart_go    (uart_go),
    .rors       (rors),
    .txdata     (txdata),
    .uart_done  (uart_done),
    .rxdata     (rxdata),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .load_done  (load_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // uart_unit model: completes each request after 1..50 cycles
  int         m_d;
  logic       m_r;
  logic [7:0] m_t;
  bit         m_ab;
  initial begin
    model_done = 1'b0;
    rxdata     = 8'h00;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && uart_go === 1'b1) begin
        m_r  = rors;
        m_t  = txdata;
        m_ab = 0;
        m_d  = $urandom_range(1, 50);
        for (int i = 0; i < m_d; i++) begin
          @(negedge clk);
          if (rstn !== 1'b1) begin
            m_ab = 1;
            break;
          end
          chk(32'(uart_go), 0, "go_before_done");
          if (m_r) chk(32'(txdata), 32'(m_t), "txdata_stable");
        end
        if (!m_ab) begin
          if (m_r) tx_log.push_back(m_t);
          else if (rx_q.size() == 0) chk(1, 0, "rx_underflow");
          else begin
            rxdata = rx_q.pop_front();
            rx_cnt++;
          end
          model_done = 1'b1;
          @(negedge clk);
          model_done = 1'b0;
        end
      end
    end
  end

  initial begin
    spur_done = 1'b0;
    forever begin
      @(negedge clk);
      spur_done = spur_en && (imem_we === 1'b1) && (rstn === 1'b1);
      if (rstn === 1'b1 && imem_we === 1'b1) begin
        wr_addr_q.push_back(imem_addr);
        wr_data_q.push_back(imem_wdata);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    rx_q.delete();
    tx_log.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic run_load(input logic [31:0] len, input bit extra_start);
    logic [7:0] exp_tx[$];
    int         cyc;
    int         s;
    int         nwr;
    bit         ok;
    logic [31:0] w;
    clear_logs();
    for (int i = 0; i < 4; i++) rx_q.push_back(len[8*i +: 8]);
    foreach (pay_q[i]) rx_q.push_back(pay_q[i]);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk(32'(busy), 1, "busy_after_start");
    chk(32'({load_done, err}), 0, "flags_cleared");
    cyc = 0;
    while (!(load_done === 1'b1 || err === 1'b1) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = (extra_start && cyc == 40) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    chk(32'(cyc < 20000), 1, "completion_timeout");
    // reference: oversize -> NAK only; otherwise one word per 4 payload bytes, ACK + sum mod 256
    ok = (len <= 32'(CAP));
    s  = 0;
    foreach (pay_q[i]) s += int'(pay_q[i]);
    if (ok) begin
      exp_tx.push_back(8'hAA);
      exp_tx.push_back(8'(s % 256));
      nwr = int'(len);
    end else begin
      exp_tx.push_back(8'h55);
      nwr = 0;
    end
    chk(32'(tx_log.size()), 32'(exp_tx.size()), "tx_count");
    foreach (exp_tx[i]) if (i < tx_log.size()) chk(32'(tx_log[i]), 32'(exp_tx[i]), "tx_byte");
    chk(32'(wr_addr_q.size()), 32'(nwr), "write_count");
    for (int i = 0; i < nwr && i < wr_addr_q.size(); i++) begin
      w = 32'(pay_q[4*i]) + 32'(pay_q[4*i+1]) * 256 + 32'(pay_q[4*i+2]) * 65536
        + 32'(pay_q[4*i+3]) * 16777216;
      chk(32'(wr_addr_q[i]), 32'(i % CAP), "write_addr");
      chk(wr_data_q[i], w, "write_data");
    end
    chk(32'(rx_q.size()), 0, "rx_all_consumed");
    chk(32'(load_done), 32'(ok), "load_done");
    chk(32'(err), 32'(!ok), "err");
    chk(32'(busy), 0, "busy_end");
  endtask

  task automatic rand_payload(input int nwords);
    pay_q.delete();
    for (int i = 0; i < 4 * nwords; i++) pay_q.push_back(8'($urandom_range(0, 255)));
  endtask

  int cyc5;
  int base5;

  initial begin
    rstn    = 1'b0;
    start   = 1'b0;
    spur_en = 0;
    repeat (3) @(negedge clk);
    chk(32'(|{uart_go, rors, txdata, imem_we, imem_addr, imem_wdata, busy, load_done, err}), 0,
        "reset_outputs");
    rstn = 1'b1;
    @(negedge clk);

    // two words 01..08, checksum 0x24
    pay_q.delete();
    for (int i = 1; i <= 8; i++) pay_q.push_back(8'(i));
    run_load(32'd2, 0);
    if (wr_data_q.size() == 2) begin
      chk(wr_data_q[0], 32'h04030201, "t1_word0");
      chk(wr_data_q[1], 32'h08070605, "t1_word1");
    end else chk(32'(wr_data_q.size()), 2, "t1_words");

    // zero length
    pay_q.delete();
    run_load(32'd0, 0);

    // oversize by one, then exactly capacity, then a value whose low bits look small
    pay_q.delete();
    run_load(32'd17, 0);
    rand_payload(16);
    run_load(32'd16, 0);
    if (wr_addr_q.size() > 0) chk(32'(wr_addr_q[$]), 32'hF, "t3_last_addr");
    pay_q.delete();
    run_load(32'h0000_0103, 0);

    // checksum wrap with all-ones word
    pay_q.delete();
    repeat (4) pay_q.push_back(8'hFF);
    run_load(32'd1, 0);
    if (wr_data_q.size() > 0) chk(wr_data_q[0], 32'hFFFF_FFFF, "t4_word");
    if (tx_log.size() > 1) chk(32'(tx_log[1]), 32'hFC, "t4_sum");

    // reset mid-word after two payload bytes
    clear_logs();
    rx_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    base5 = rx_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc5 = 0;
    while (rx_cnt - base5 < 6 && cyc5 < 2000) begin
      @(negedge clk);
      cyc5++;
    end
    chk(32'(cyc5 < 2000), 1, "t5_wait_bytes");
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk(32'(|{uart_go, rors, txdata, imem_we, imem_addr, imem_wdata, busy, load_done, err}), 0,
        "t5_reset_outputs");
    chk(32'(wr_addr_q.size()), 0, "t5_no_write");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rand_payload(3);
    run_load(32'd3, 0);

    // start while busy plus spurious uart_done during WRITE
    spur_en = 1;
    rand_payload(10);
    run_load(32'd10, 1);
    spur_en = 0;

    // randomized loads, including random oversize counts
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, CAP);
      rand_payload(n);
      run_load(32'(n), 0);
    end
    pay_q.delete();
    run_load(32'($urandom_range(CAP + 1, 32'h7FFF_FFFF)), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
